step_sequencer_core: RTL and testbench

STEP_SEQUENCER_CORE -- requirements
Module: step_sequencer_core

---
 rtl/step_sequencer_core.sv | 210 +++++++++++++++++++++
 tb/tb_step_sequencer_core.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer_core.sv
// Step sequencer core: register file, IDLE/RUN/DONE sequencer FSM, step
// timing, step-index stepping (forward/reverse/ping-pong), a gated tone
// generator and LED display.
module step_sequencer_core #(
   parameter int STEPS    = 8,
   parameter int PERIOD_W = 28,
   parameter int TONE_W   = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      we,
   input  logic [1:0]                waddr,
   input  logic [31:0]               wdata,
   input  logic                      run,
   output logic                      snd_out,
   output logic [STEPS-1:0]          led_out,
   output logic [$clog2(STEPS)-1:0]  step_idx,
   output logic                      step_tick,
   output logic                      wrap,
   output logic                      done
);

   localparam int IW = $clog2(STEPS);
   localparam logic [IW-1:0]       LAST_IDX   = IW'(STEPS - 1);
   localparam logic [IW-1:0]       FIRST_IDX  = '0;
   localparam logic [STEPS-1:0]    ONE_HOT0   = STEPS'(1);
   localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(6_250_000);
   localparam logic [TONE_W-1:0]   HALF_RST   = TONE_W'(25_000);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [STEPS-1:0]    pattern;
   logic [PERIOD_W-1:0] period;
   logic [TONE_W-1:0]   half;
   logic                ctrl_oneshot;
   logic [1:0]          ctrl_gate;
   logic [1:0]          ctrl_dir;

   logic [PERIOD_W-1:0] step_cnt;
   logic [TONE_W-1:0]   tone_cnt;
   logic                tone_sq;
   logic                dir_up;

   logic [PERIOD_W-1:0] len_m1;
   logic [PERIOD_W-1:0] gate_len;
   logic [PERIOD_W-1:0] gate_lim;
   logic                gate_on;
   logic                boundary;
   logic [IW-1:0]       next_idx;
   logic                next_dir_up;
   logic                next_wrap;
   logic                ctrl_wr;

   // Write data bits beyond the configured field widths are intentionally dropped.
   logic unused_wdata;
   assign unused_wdata = ^wdata;

   assign ctrl_wr = we && (waddr == 2'd3);

   // Register file: new values become visible the cycle after the write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pattern      <= '0;
         period       <= PERIOD_RST;
         half         <= HALF_RST;
         ctrl_oneshot <= 1'b0;
         ctrl_gate    <= 2'd0;
         ctrl_dir     <= 2'd0;
      end else if (we) begin
         case (waddr)
            2'd0: pattern <= wdata[STEPS-1:0];
            2'd1: period  <= wdata[PERIOD_W-1:0];
            2'd2: half    <= wdata[TONE_W-1:0];
            default: begin
               ctrl_oneshot <= wdata[4];
               ctrl_gate    <= wdata[3:2];
               ctrl_dir     <= wdata[1:0];
            end
         endcase
      end
   end

   // Step length, gate window and boundary detect; PERIOD=0 behaves as 1.
   always_comb begin
      len_m1   = (period == '0) ? '0 : period - PERIOD_W'(1);
      gate_len = period >> ctrl_gate;
      gate_lim = (gate_len == '0) ? PERIOD_W'(1) : gate_len;
      gate_on  = (step_cnt < gate_lim);
      boundary = (step_cnt >= len_m1);
   end

   // Next step index, ping-pong direction and wrap flag for the coming advance.
   always_comb begin
      next_idx    = step_idx;
      next_dir_up = dir_up;
      next_wrap   = 1'b0;
      case (ctrl_dir)
         2'd1: begin
            if (step_idx == FIRST_IDX) begin
               next_idx  = LAST_IDX;
               next_wrap = 1'b1;
            end else begin
               next_idx = step_idx - IW'(1);
            end
         end
         2'd2: begin
            if (dir_up) begin
               if (step_idx == LAST_IDX) begin
                  next_idx    = step_idx - IW'(1);
                  next_dir_up = 1'b0;
                  next_wrap   = (next_idx == FIRST_IDX);
               end else begin
                  next_idx = step_idx + IW'(1);
               end
            end else begin
               if (step_idx == FIRST_IDX) begin
                  next_idx    = step_idx + IW'(1);
                  next_dir_up = 1'b1;
               end else begin
                  next_idx  = step_idx - IW'(1);
                  next_wrap = (next_idx == FIRST_IDX);
               end
            end
         end
         default: begin
            if (step_idx == LAST_IDX) begin
               next_idx  = FIRST_IDX;
               next_wrap = 1'b1;
            end else begin
               next_idx = step_idx + IW'(1);
            end
         end
      endcase
   end

   // Sequencer FSM with step counter, tone generator and registered pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         step_cnt  <= '0;
         step_idx  <= '0;
         tone_cnt  <= '0;
         tone_sq   <= 1'b0;
         dir_up    <= 1'b1;
         step_tick <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         step_tick <= 1'b0;
         wrap      <= 1'b0;
         case (state)
            IDLE: begin
               step_cnt <= '0;
               if (run) begin
                  state    <= RUN;
                  tone_cnt <= '0;
                  tone_sq  <= 1'b0;
               end
            end
            RUN: begin
               if (!run) begin
                  // Stopping wins over a coincident boundary: no advance.
                  state    <= IDLE;
                  step_cnt <= '0;
               end else if (boundary) begin
                  step_cnt  <= '0;
                  step_tick <= 1'b1;
                  step_idx  <= next_idx;
                  dir_up    <= next_dir_up;
                  tone_cnt  <= '0;
                  tone_sq   <= 1'b0;
                  if (next_wrap) begin
                     wrap <= 1'b1;
                     if (ctrl_oneshot) state <= DONE;
                  end
               end else begin
                  step_cnt <= step_cnt + PERIOD_W'(1);
                  if (half == '0) begin
                     tone_cnt <= '0;
                     tone_sq  <= 1'b0;
                  end else if (tone_cnt >= half - TONE_W'(1)) begin
                     tone_cnt <= '0;
                     tone_sq  <= ~tone_sq;
                  end else begin
                     tone_cnt <= tone_cnt + TONE_W'(1);
                  end
               end
            end
            default: begin
               step_cnt <= '0;
               if (!run) state <= IDLE;
            end
         endcase
         // A CTRL write restarts ping-pong travel upward.
         if (ctrl_wr) dir_up <= 1'b1;
      end
   end

   // Output decode from registered state.
   always_comb begin
      snd_out = tone_sq & pattern[step_idx] & gate_on & (state == RUN);
      led_out = pattern | ((state == RUN) ? (ONE_HOT0 << step_idx) : '0);
      done    = (state == DONE);
   end

endmodule

// File: tb/tb_step_sequencer_core.sv
// Directed testbench for step_sequencer_core (STEPS=8 defaults).
module tb_step_sequencer_core;

   logic        clk;
   logic        rst;
   logic        we;
   logic [1:0]  waddr;
   logic [31:0] wdata;
   logic        run;
   logic        snd_out;
   logic [7:0]  led_out;
   logic [2:0]  step_idx;
   logic        step_tick;
   logic        wrap;
   logic        done;

   int checks = 0;
   int errors = 0;
   int pp_seq [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
   int rev_seq [4] = '{2, 1, 0, 7};

   step_sequencer_core #(.STEPS(8), .PERIOD_W(28), .TONE_W(20)) dut (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .run       (run),
      .snd_out   (snd_out),
      .led_out   (led_out),
      .step_idx  (step_idx),
      .step_tick (step_tick),
      .wrap      (wrap),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      we    = 1'b1;
      waddr = a;
      wdata = d;
      tick(1);
      we    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(1);
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; waddr = 2'd0; wdata = 32'd0; run = 1'b0;

      // Reset state
      tick(2);
      chk("rst_snd",  32'(snd_out),   32'd0);
      chk("rst_led",  32'(led_out),   32'd0);
      chk("rst_idx",  32'(step_idx),  32'd0);
      chk("rst_tick", 32'(step_tick), 32'd0);
      chk("rst_done", 32'(done),      32'd0);
      rst = 1'b1;
      tick(1);
      chk("post_rst_wrap", 32'(wrap), 32'd0);
      chk("post_rst_led",  32'(led_out), 32'd0);

      // Forward, PERIOD=4
      wr(2'd0, 32'hFF);
      wr(2'd1, 32'd4);
      wr(2'd3, 32'd0);
      run = 1'b1;
      tick(1);
      chk("fwd_led", 32'(led_out), 32'hFF);
      for (int s = 1; s <= 8; s++) begin
         tick(3);
         chk("fwd_notick", 32'(step_tick), 32'd0);
         tick(1);
         chk("fwd_tick", 32'(step_tick), 32'd1);
         chk("fwd_idx",  32'(step_idx),  32'(s % 8));
         chk("fwd_wrap", 32'(wrap),      (s == 8) ? 32'd1 : 32'd0);
      end
      tick(1);
      chk("fwd_wrap_end", 32'(wrap), 32'd0);
      tick(3);
      chk("fwd_idx1", 32'(step_idx), 32'd1);
      tick(1);
      run = 1'b0;
      tick(1);
      chk("pause_idx", 32'(step_idx), 32'd1);
      chk("pause_led", 32'(led_out),  32'hFF);
      run = 1'b1;
      tick(1);
      tick(3);
      run = 1'b0;
      tick(1);
      chk("stop_dom_tick", 32'(step_tick), 32'd0);
      chk("stop_dom_idx",  32'(step_idx),  32'd1);
      run = 1'b1;
      tick(1);
      tick(4);
      chk("resume_tick", 32'(step_tick), 32'd1);
      chk("resume_idx",  32'(step_idx),  32'd2);

      // Reset mid-sequence
      tick(2);
      rst = 1'b0;
      #2;
      chk("mid_rst_snd",  32'(snd_out),   32'd0);
      chk("mid_rst_led",  32'(led_out),   32'd0);
      chk("mid_rst_idx",  32'(step_idx),  32'd0);
      chk("mid_rst_tick", 32'(step_tick), 32'd0);
      chk("mid_rst_wrap", 32'(wrap),      32'd0);
      chk("mid_rst_done", 32'(done),      32'd0);
      run = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(3);
      chk("after_rst_led",  32'(led_out),   32'd0);
      chk("after_rst_tick", 32'(step_tick), 32'd0);
      chk("after_rst_idx",  32'(step_idx),  32'd0);

      // Ping-pong, PERIOD=2
      wr(2'd0, 32'h80);
      wr(2'd1, 32'd2);
      wr(2'd3, 32'd2);
      run = 1'b1;
      tick(1);
      chk("pp_led0", 32'(led_out), 32'h81);
      for (int i = 0; i < 15; i++) begin
         tick(1);
         chk("pp_notick", 32'(step_tick), 32'd0);
         tick(1);
         chk("pp_idx",  32'(step_idx), 32'(pp_seq[i]));
         chk("pp_wrap", 32'(wrap),     (pp_seq[i] == 0) ? 32'd1 : 32'd0);
         chk("pp_led",  32'(led_out),  32'h80 | (32'd1 << pp_seq[i]));
      end
      run = 1'b0;
      tick(1);
      do_reset();

      // Tone and gate: HALF=3, PERIOD=64, GATE=1, PATTERN=0x01
      wr(2'd0, 32'h01);
      wr(2'd1, 32'd64);
      wr(2'd2, 32'd3);
      wr(2'd3, 32'h04);
      run = 1'b1;
      tick(1);
      for (int k = 0; k < 64; k++) begin
         chk("tone_step0", 32'(snd_out), (k < 32 && ((k / 3) % 2) == 1) ? 32'd1 : 32'd0);
         tick(1);
      end
      for (int i = 0; i < 28; i++) begin
         chk("tone_other", 32'(snd_out), 32'd0);
         tick(16);
      end
      run = 1'b0;
      tick(1);
      do_reset();

      // One-shot, PERIOD=2
      wr(2'd1, 32'd2);
      wr(2'd3, 32'h10);
      run = 1'b1;
      tick(1);
      chk("os_led_run", 32'(led_out), 32'h01);
      tick(15);
      chk("os_done_early", 32'(done), 32'd0);
      tick(1);
      chk("os_wrap", 32'(wrap),      32'd1);
      chk("os_done", 32'(done),      32'd1);
      chk("os_idx",  32'(step_idx),  32'd0);
      chk("os_tick", 32'(step_tick), 32'd1);
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk("os_hold_tick", 32'(step_tick), 32'd0);
      end
      chk("os_hold_done", 32'(done),    32'd1);
      chk("os_hold_led",  32'(led_out), 32'd0);
      run = 1'b0;
      tick(1);
      chk("os_clear_done", 32'(done), 32'd0);
      run = 1'b1;
      tick(1);
      chk("os_restart_done", 32'(done), 32'd0);
      tick(2);
      chk("os_restart_tick", 32'(step_tick), 32'd1);
      chk("os_restart_idx",  32'(step_idx),  32'd1);

      // Period shrink mid-step
      wr(2'd3, 32'd0);
      wr(2'd1, 32'd100);
      chk("shr_old_tick", 32'(step_tick), 32'd1);
      chk("shr_old_idx",  32'(step_idx),  32'd2);
      tick(50);
      we = 1'b1; waddr = 2'd1; wdata = 32'd10;
      tick(1);
      we = 1'b0;
      chk("shr_write_tick", 32'(step_tick), 32'd0);
      tick(1);
      chk("shr_tick", 32'(step_tick), 32'd1);
      chk("shr_idx",  32'(step_idx),  32'd3);
      tick(9);
      chk("shr_len_notick", 32'(step_tick), 32'd0);
      tick(1);
      chk("shr_len_tick", 32'(step_tick), 32'd1);
      chk("shr_len_idx",  32'(step_idx),  32'd4);

      // Reverse, PERIOD=10
      wr(2'd3, 32'd1);
      tick(8);
      chk("rev_notick", 32'(step_tick), 32'd0);
      tick(1);
      chk("rev_idx3", 32'(step_idx), 32'd3);
      for (int i = 0; i < 4; i++) begin
         tick(10);
         chk("rev_idx",  32'(step_idx), 32'(rev_seq[i]));
         chk("rev_wrap", 32'(wrap),     (rev_seq[i] == 7) ? 32'd1 : 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
